// File: rtl/fifo_non2n_pkg.sv
// Shared pointer helpers for the non-power-of-two FIFO: lap-tagged increment and occupancy.
// Used by both the read-side controller and the write-side pointer logic.
package fifo_non2n_pkg;

    localparam int unsigned DEF_FIFO_DEPTH = 520;
    localparam int unsigned DEF_PTR_WIDTH  = 10;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    // Pointer split into lap bit and index, index held wide so any depth fits.
    typedef struct packed {
        logic        lap;
        logic [31:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p, input logic [31:0] depth);
        ptr_t r;
        if (p.idx == (depth - 32'd1)) begin
            r.lap = ~p.lap;
            r.idx = 32'd0;
        end else begin
            r.lap = p.lap;
            r.idx = p.idx + 32'd1;
        end
        return r;
    endfunction

    // A result above depth (including a negative wrap) marks an inconsistent pointer pair.
    function automatic logic [32:0] ptr_count(input ptr_t w, input ptr_t r, input logic [31:0] depth);
        logic [32:0] c;
        if (w.lap == r.lap) begin
            c = {1'b0, w.idx} - {1'b0, r.idx};
        end else begin
            c = {1'b0, depth} - {1'b0, r.idx} + {1'b0, w.idx};
        end
        return c;
    endfunction

endpackage

// File: rtl/fifo_out_buf2.sv
// Two-entry ordered output buffer; head is always entry 0.
// Simultaneous push and pop advance the head and append the new word in one cycle.
module fifo_out_buf2
    import fifo_non2n_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid
);

    logic [DATA_WIDTH-1:0] ent0_r;
    logic [DATA_WIDTH-1:0] ent1_r;
    logic [1:0]            occ_r;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] ent0_next_s;
    logic [DATA_WIDTH-1:0] ent1_next_s;
    logic [1:0]            occ_next_s;

    // Next-state of the two entries and the fill level.
    always_comb begin
        ent0_next_s = ent0_r;
        ent1_next_s = ent1_r;
        occ_next_s  = occ_r;
        case ({push, pop})
            2'b10: begin
                if (occ_r == 2'd0) begin
                    ent0_next_s = push_data;
                end else begin
                    ent1_next_s = push_data;
                end
                occ_next_s = occ_r + 2'd1;
            end
            2'b01: begin
                ent0_next_s = ent1_r;
                occ_next_s  = occ_r - 2'd1;
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    ent0_next_s = push_data;
                end else begin
                    ent0_next_s = ent1_r;
                    ent1_next_s = push_data;
                end
            end
            default: begin
                occ_next_s = occ_r;
            end
        endcase
    end

    // Entry, fill-level and registered valid state.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            ent0_r  <= '0;
            ent1_r  <= '0;
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            ent0_r  <= ent0_next_s;
            ent1_r  <= ent1_next_s;
            occ_r   <= occ_next_s;
            valid_r <= (occ_next_s != 2'd0);
        end
    end

    assign occ        = occ_r;
    assign head_data  = ent0_r;
    assign head_valid = valid_r;

endmodule

// File: rtl/fifo_rd_ctrl_non2n.sv
// Read-side controller for the non-power-of-two FIFO: lap-tagged read pointer, occupancy,
// RAM fetch scheduling and a two-entry prefetch buffer feeding a valid/ready stream.
module fifo_rd_ctrl_non2n
    import fifo_non2n_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned PTR_WIDTH  = DEF_PTR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [PTR_WIDTH:0]    wr_ptr,
    output logic                  mem_ren,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [PTR_WIDTH:0]    rd_ptr,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  ptr_err
);

    localparam logic [31:0] DEPTH_W = 32'(FIFO_DEPTH);

    logic [PTR_WIDTH:0]   rd_ptr_r;
    logic [PTR_WIDTH-1:0] count_r;
    logic                 empty_r;
    logic                 inflight_r;
    logic                 ptr_err_r;

    logic [PTR_WIDTH:0]   rd_ptr_next_s;
    logic [1:0]           occ_s;
    logic                 pop_s;
    logic                 fetch_s;
    logic                 err_set_s;
    logic [32:0]          occ_calc_s;
    ptr_t                 rd_cur_s;
    ptr_t                 rd_inc_s;
    ptr_t                 rd_nxt_s;
    ptr_t                 wr_cur_s;

    // Fetch decision, next read pointer and occupancy against the writer's pointer.
    always_comb begin
        rd_cur_s = '{lap: rd_ptr_r[PTR_WIDTH], idx: 32'(rd_ptr_r[PTR_WIDTH-1:0])};
        wr_cur_s = '{lap: wr_ptr[PTR_WIDTH], idx: 32'(wr_ptr[PTR_WIDTH-1:0])};
        rd_inc_s = ptr_inc(rd_cur_s, DEPTH_W);
        pop_s    = dout_valid & dout_ready;

        // Keep buffered plus in-flight words at two or fewer after this cycle's pop.
        if (rrst || empty_r) begin
            fetch_s = 1'b0;
        end else begin
            fetch_s = (({1'b0, occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
        end

        if (fetch_s) begin
            rd_ptr_next_s = {rd_inc_s.lap, PTR_WIDTH'(rd_inc_s.idx)};
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        rd_nxt_s   = '{lap: rd_ptr_next_s[PTR_WIDTH], idx: 32'(rd_ptr_next_s[PTR_WIDTH-1:0])};
        occ_calc_s = ptr_count(wr_cur_s, rd_nxt_s, DEPTH_W);
        err_set_s  = (wr_cur_s.idx >= DEPTH_W) || (occ_calc_s > {1'b0, DEPTH_W});
    end

    // Pointer, occupancy, in-flight tag and sticky error state.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_ptr_r   <= '0;
            count_r    <= '0;
            empty_r    <= 1'b1;
            inflight_r <= 1'b0;
            ptr_err_r  <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= PTR_WIDTH'(occ_calc_s);
            empty_r    <= (occ_calc_s == 33'd0);
            inflight_r <= fetch_s;
            ptr_err_r  <= ptr_err_r | err_set_s;
        end
    end

    // Clearing inflight_r on reset drops any RAM word still returning.
    fifo_out_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .rclk       (rclk),
        .rrst       (rrst),
        .push       (inflight_r),
        .push_data  (mem_rdata),
        .pop        (pop_s),
        .occ        (occ_s),
        .head_data  (dout),
        .head_valid (dout_valid)
    );

    assign mem_ren   = fetch_s;
    assign mem_raddr = rd_ptr_r[PTR_WIDTH-1:0];
    assign rd_ptr    = rd_ptr_r;
    assign count     = count_r;
    assign empty     = empty_r;
    assign ptr_err   = ptr_err_r;

endmodule

// File: doc/fifo_rd_ctrl_non2n.md
# fifo_rd_ctrl_non2n

Read-side controller for the single-clock, non-power-of-two-depth FIFO. It is the reader counterpart to the write-side pointer and entry-count logic. It tracks a lap-tagged read pointer that wraps at FIFO_DEPTH and computes occupancy against the writer's pointer. It issues reads to the synchronous FIFO RAM and presents data on a valid/ready stream through a two-entry prefetch buffer. It exports its read pointer so the writer can derive `full`.

## Interface
- FIFO_DEPTH, 520, number of entries; any value 2..2^PTR_WIDTH-1
- PTR_WIDTH, 10, address width; 2^PTR_WIDTH > FIFO_DEPTH required
- DATA_WIDTH, 8, word width
- rclk  in  1  clock; the block uses one clock
- rrst  in  1  reset, synchronous, active-high
- wr_ptr  in  PTR_WIDTH+1  writer pointer, same clock; MSB = lap bit, low bits 0..FIFO_DEPTH-1
- mem_ren  out  1  RAM read enable (combinational)
- mem_raddr  out  PTR_WIDTH  RAM read address = low bits of rd_ptr
- mem_rdata  in  DATA_WIDTH  RAM data, valid the cycle after the mem_ren edge
- dout  out  DATA_WIDTH  stream data
- dout_valid  out  1  stream valid (registered)
- dout_ready  in  1  stream ready
- rd_ptr  out  PTR_WIDTH+1  read pointer, lap bit in MSB, to writer
- count  out  PTR_WIDTH  entries in RAM not yet fetched (registered)
- empty  out  1  count==0 (registered)
- ptr_err  out  1  sticky: wr_ptr low bits ≥ FIFO_DEPTH, or computed count > FIFO_DEPTH

## Operation
- Reset values: rd_ptr=0, count=0, empty=1, dout_valid=0, dout=0, ptr_err=0. Prefetch buffer and in-flight tag are cleared. mem_ren=0 while rrst is high.
- Pointer increment: when the low bits equal FIFO_DEPTH-1, they wrap to 0 and the lap bit toggles. Otherwise the low bits increment by 1.
- Occupancy, computed from wr_ptr and the next-state rd_ptr:
  - lap bits equal: w-r
  - lap bits differ: FIFO_DEPTH-r+w
  - The result is registered into count. empty<=(result==0).
- Fetch rule: mem_ren = !empty && (occ + inflight - pop) < 2.
  - occ is the number of buffer entries (0..2).
  - inflight is the registered previous mem_ren.
  - pop = dout_valid && dout_ready.
- rd_ptr advances on every mem_ren edge.
- Capture: when inflight=1, mem_rdata is written into the buffer at the next edge. Order is preserved.
- dout/dout_valid always reflect the buffer head. dout is stable while dout_valid && !dout_ready.
- Simultaneous pop and capture in the same cycle: the buffer head advances and the new word is appended. No drop or duplicate.
- Simultaneous wr_ptr advance and mem_ren: count reflects both, since it uses next rd_ptr and current wr_ptr.
- Full (count==FIFO_DEPTH) is legal. empty=0 and fetch proceeds normally.
- ptr_err sets and holds until rrst. Behaviour on illegal pointers is otherwise undefined.
- Reset mid-operation: any mem_rdata returning after rrst is discarded. The writer must be reset in the same cycle.

## Timing
- wr_ptr changes at edge E0:
  - E1: empty=0 and count updated.
  - Cycle E1–E2: mem_ren=1.
  - E2: rd_ptr increments.
  - E3: dout_valid=1.
  - Latency is 3 cycles.
- Sustained throughput is one word per cycle with dout_ready held high.
- Last entry fetched at edge E: empty=1 at E, with no overread in the following cycle.
- Under backpressure, at most 2 words are outstanding beyond the RAM: occ + inflight ≤ 2.

## Structure
- Package fifo_non2n_pkg holds:
  - Default depth and width constants.
  - Function ptr_inc (wrap plus lap toggle).
  - Function ptr_count (lap-aware occupancy).
  - The writer block shares both functions.
- Sub-module fifo_out_buf2: a two-entry ordered buffer with push, pop, occ, and head outputs.
- Top level holds the pointer, count, fetch logic and error logic.

## Test plan
- Reset: hold rrst for 2 cycles → empty=1, count=0, rd_ptr=0, dout_valid=0, mem_ren=0, ptr_err=0.
- Basic drain: with dout_ready=1, step wr_ptr 0→3 at E0 → mem_raddr 0,1,2 on consecutive cycles. dout shows RAM words 0,1,2 in order, first at E3. empty=1 after the third fetch edge and rd_ptr ends at 3.
- Wrap: rd_ptr={0,518}, wr_ptr={1,4} → count=6. Fetch addresses are 518,519,0,1,2,3 and rd_ptr ends at {1,4}.
- Backpressure: 5 entries available, dout_ready=0 → exactly 2 mem_ren pulses, dout stable, count=3. Raise dout_ready → remaining 3 words arrive in order with no drop or duplicate.
- Full: rd_ptr={0,100}, wr_ptr={1,100} → count=520, empty=0, ptr_err=0. Then wr_ptr low bits=600 → ptr_err=1 sticky until rrst.
- Mid-stream reset: assert rrst in the cycle inflight=1 → next cycle dout_valid=0 and count=0, and the returning mem_rdata is never presented.
